// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared types and constants for the PC fetch unit
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_timeout_counter.sv
// rtl/fetch_timeout_counter.sv - counts REQ cycles without an ack, flags the last allowed one
module fetch_timeout_counter #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted in the cycle that would complete LIMIT ack-less REQ cycles.
    assign expired = enable && !clear && (count_q == 8'(LIMIT - 1));

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - fetch FSM: request, issue, sticky fault on timeout or misaligned PC
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          ACK_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [31:0] PC_last,
    input  logic               Stall,
    output logic               IMemReq,
    output logic        [31:0] IMemAddr,
    input  logic               IMemAck,
    input  logic        [31:0] IMemData,
    output logic signed [31:0] PC,
    output logic signed [31:0] PCPlus4,
    output logic signed [31:0] PCJump,
    output logic        [31:0] Instr,
    output logic               InstrValid,
    output logic               Fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         fault_q, fault_d;
    logic [31:0]  pc_plus4;
    logic         to_clear, to_enable, to_expired;

    assign to_enable = (state_q == ST_REQ) && !IMemAck;
    assign to_clear  = (state_q != ST_REQ) || IMemAck;

    fetch_timeout_counter #(
        .LIMIT (ACK_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (to_clear),
        .enable  (to_enable),
        .expired (to_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_REQ: begin
                if (IMemAck) begin
                    state_d = ST_ISSUE;
                end else if (to_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_ISSUE: begin
                if (!Stall) begin
                    state_d = (PC_last[1:0] == 2'b00) ? ST_REQ : ST_FAULT;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase
    end

    always_comb begin
        IMemReq    = 1'b0;
        InstrValid = 1'b0;
        case (state_q)
            ST_REQ:   IMemReq    = 1'b1;
            ST_ISSUE: InstrValid = 1'b1;
            default: begin
                IMemReq    = 1'b0;
                InstrValid = 1'b0;
            end
        endcase
    end

    // Datapath registers: capture only on an ack in REQ, redirect only on an aligned unstalled issue.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        fault_d = fault_q || (state_q != ST_FAULT && state_d == ST_FAULT);
        if (state_q == ST_REQ && IMemAck) begin
            instr_d = IMemData;
        end
        if (state_q == ST_ISSUE && !Stall && PC_last[1:0] == 2'b00) begin
            pc_d = PC_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    assign pc_plus4 = pc_q + INSTR_BYTES;
    assign IMemAddr = pc_q;
    assign PC       = pc_q;
    assign PCPlus4  = pc_plus4;
    assign PCJump   = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    assign Instr    = instr_q;
    assign Fault    = fault_q;

endmodule
